// File: rtl/pixel_coord_gen.sv
// Raster-order pixel coordinate generator feeding one depth engine.
// One start per pixel; advances only after the engine reports its write.
module pixel_coord_gen #(
   parameter int WORD_LENGTH = 32,
   parameter int FRAC        = 28,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic                   frame_go,
   input  logic [WORD_LENGTH-1:0] re_left,
   input  logic [WORD_LENGTH-1:0] im_top,
   input  logic [WORD_LENGTH-1:0] step,
   input  logic                   engine_written,
   output logic [WORD_LENGTH-1:0] re_c,
   output logic [WORD_LENGTH-1:0] im_c,
   output logic                   engine_start,
   output logic [9:0]             x,
   output logic [9:0]             y,
   output logic                   busy,
   output logic                   frame_done
);

   if (FRAC < 0 || FRAC >= WORD_LENGTH) begin : g_bad_frac
      $error("FRAC out of range");
   end
   if (H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 1024) begin : g_bad_res
      $error("resolution out of range");
   end

   localparam logic [9:0] X_LAST = 10'(H_RES - 1);
   localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ADVANCE
   } state_t;

   state_t                 state;
   logic [WORD_LENGTH-1:0] re_base;
   logic [WORD_LENGTH-1:0] step_q;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state        <= IDLE;
         re_base      <= '0;
         step_q       <= '0;
         re_c         <= '0;
         im_c         <= '0;
         x            <= '0;
         y            <= '0;
         engine_start <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         engine_start <= 1'b0;
         frame_done   <= 1'b0;
         unique case (state)
            IDLE: begin
               // frame_done still high means the frame only just closed
               if (frame_go && !frame_done) begin
                  re_base      <= re_left;
                  step_q       <= step;
                  re_c         <= re_left;
                  im_c         <= im_top;
                  x            <= '0;
                  y            <= '0;
                  busy         <= 1'b1;
                  engine_start <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (engine_written) begin
                  state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (x != X_LAST) begin
                  x            <= x + 10'd1;
                  re_c         <= re_c + step_q;
                  engine_start <= 1'b1;
                  state        <= ISSUE;
               end else if (y != Y_LAST) begin
                  x            <= '0;
                  y            <= y + 10'd1;
                  re_c         <= re_base;
                  im_c         <= im_c - step_q;
                  engine_start <= 1'b1;
                  state        <= ISSUE;
               end else begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed bench for pixel_coord_gen: 4x3, 2x2 wrap and 1x1 instances.
// The bench plays the depth engine, answering 5 cycles after each start.
module tb_pixel_coord_gen;

   logic        sysclk;
   logic        reset;
   logic        go;
   logic        wr;
   logic [31:0] rl;
   logic [31:0] it;
   logic [31:0] stp;
   int          sel;

   logic [31:0] re_c [3];
   logic [31:0] im_c [3];
   logic [9:0]  xs [3];
   logic [9:0]  ys [3];
   logic        st [3];
   logic        bz [3];
   logic        fd [3];

   int cmp = 0;
   int mism = 0;
   int starts = 0;
   int dones = 0;

   wire go0 = go && (sel == 0);
   wire go1 = go && (sel == 1);
   wire go2 = go && (sel == 2);
   wire wr0 = wr && (sel == 0);
   wire wr1 = wr && (sel == 1);
   wire wr2 = wr && (sel == 2);

   wire [31:0] cur_re = re_c[sel];
   wire [31:0] cur_im = im_c[sel];
   wire [9:0]  cur_x  = xs[sel];
   wire [9:0]  cur_y  = ys[sel];
   wire        cur_st = st[sel];
   wire        cur_bz = bz[sel];
   wire        cur_fd = fd[sel];

   pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(28), .H_RES(4), .V_RES(3)) u0 (
      .sysclk(sysclk), .reset(reset), .frame_go(go0),
      .re_left(rl), .im_top(it), .step(stp), .engine_written(wr0),
      .re_c(re_c[0]), .im_c(im_c[0]), .engine_start(st[0]),
      .x(xs[0]), .y(ys[0]), .busy(bz[0]), .frame_done(fd[0]));

   pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(28), .H_RES(2), .V_RES(2)) u1 (
      .sysclk(sysclk), .reset(reset), .frame_go(go1),
      .re_left(rl), .im_top(it), .step(stp), .engine_written(wr1),
      .re_c(re_c[1]), .im_c(im_c[1]), .engine_start(st[1]),
      .x(xs[1]), .y(ys[1]), .busy(bz[1]), .frame_done(fd[1]));

   pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(28), .H_RES(1), .V_RES(1)) u2 (
      .sysclk(sysclk), .reset(reset), .frame_go(go2),
      .re_left(rl), .im_top(it), .step(stp), .engine_written(wr2),
      .re_c(re_c[2]), .im_c(im_c[2]), .engine_start(st[2]),
      .x(xs[2]), .y(ys[2]), .busy(bz[2]), .frame_done(fd[2]));

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      if (cur_st === 1'b1) starts++;
      if (cur_fd === 1'b1) dones++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      cmp++;
      assert (got === exp) else begin
         mism++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic go_frame();
      go = 1'b1;
      tick(1);
      go = 1'b0;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 40 && cur_st !== 1'b1; i++) tick(1);
      chk("start_seen", 32'(cur_st), 32'd1);
   endtask

   // one pixel: check coordinates at the start pulse, then answer
   task automatic pix(input int ex, input int ey, input int stall,
                      input bit spur);
      int s0;
      wait_start();
      chk("re_c", cur_re, 32'(rl + 32'(ex) * stp));
      chk("im_c", cur_im, 32'(it - 32'(ey) * stp));
      chk("x", 32'(cur_x), 32'(ex));
      chk("y", 32'(cur_y), 32'(ey));
      if (spur) begin
         go = 1'b1;
         wr = 1'b1;
         tick(1);
         go = 1'b0;
         wr = 1'b0;
         tick(3);
      end else begin
         tick(4);
      end
      if (stall > 0) begin
         s0 = starts;
         tick(stall);
         chk("stall_starts", 32'(starts), 32'(s0));
         chk("stall_re", cur_re, 32'(rl + 32'(ex) * stp));
         chk("stall_im", cur_im, 32'(it - 32'(ey) * stp));
         chk("stall_x", 32'(cur_x), 32'(ex));
         chk("stall_y", 32'(cur_y), 32'(ey));
         chk("stall_busy", 32'(cur_bz), 32'd1);
      end
      wr = 1'b1;
      tick(1);
      wr = 1'b0;
   endtask

   task automatic end_frame(input int s0, input int d0, input int n);
      chk("done_early", 32'(cur_fd), 32'd0);
      tick(1);
      chk("frame_done", 32'(cur_fd), 32'd1);
      chk("busy_end", 32'(cur_bz), 32'd0);
      tick(1);
      chk("done_pulse", 32'(cur_fd), 32'd0);
      tick(5);
      chk("starts", 32'(starts - s0), 32'(n));
      chk("dones", 32'(dones - d0), 32'd1);
   endtask

   initial begin
      int s0;
      int d0;
      sel   = 0;
      reset = 1'b1;
      go    = 1'b0;
      wr    = 1'b0;
      rl    = 32'hE000_0000;
      it    = 32'h1000_0000;
      stp   = 32'h0400_0000;
      tick(3);
      chk("rst_re", re_c[0], 32'd0);
      chk("rst_im", im_c[0], 32'd0);
      chk("rst_x", 32'(xs[0]), 32'd0);
      chk("rst_y", 32'(ys[0]), 32'd0);
      chk("rst_start", 32'(st[0]), 32'd0);
      chk("rst_busy", 32'(bz[0]), 32'd0);
      chk("rst_done", 32'(fd[0]), 32'd0);
      reset = 1'b0;
      tick(2);

      // full 4x3 walk with a long stall at pixel 5, noise at pixel 8
      s0 = starts;
      d0 = dones;
      go_frame();
      chk("busy_on", 32'(cur_bz), 32'd1);
      for (int yy = 0; yy < 3; yy++) begin
         for (int xx = 0; xx < 4; xx++) begin
            pix(xx, yy, (yy == 1 && xx == 1) ? 100 : 0,
                (yy == 2 && xx == 0));
         end
      end
      chk("last_re", re_c[0], 32'hEC00_0000);
      chk("last_im", im_c[0], 32'h0800_0000);
      end_frame(s0, d0, 12);

      // abort with reset while waiting on pixel 7
      go_frame();
      for (int k = 0; k < 7; k++) pix(k % 4, k / 4, 0, 1'b0);
      wait_start();
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("abort_re", re_c[0], 32'd0);
      chk("abort_im", im_c[0], 32'd0);
      chk("abort_x", 32'(xs[0]), 32'd0);
      chk("abort_y", 32'(ys[0]), 32'd0);
      chk("abort_busy", 32'(bz[0]), 32'd0);
      chk("abort_start", 32'(st[0]), 32'd0);
      s0 = starts;
      wr = 1'b1;
      tick(1);
      wr = 1'b0;
      tick(8);
      chk("abort_nostart", 32'(starts), 32'(s0));
      chk("abort_idle", 32'(bz[0]), 32'd0);
      go_frame();
      pix(0, 0, 0, 1'b0);
      pix(1, 0, 0, 1'b0);

      // wrap of re_c and re-load at the new row
      sel = 1;
      rl  = 32'h7FFF_FFFF;
      it  = 32'h0000_0000;
      stp = 32'h0000_0001;
      tick(2);
      s0 = starts;
      d0 = dones;
      go_frame();
      pix(0, 0, 0, 1'b0);
      pix(1, 0, 0, 1'b0);
      pix(0, 1, 0, 1'b0);
      chk("wrap_reload", re_c[1], 32'h7FFF_FFFF);
      chk("wrap_im", im_c[1], 32'hFFFF_FFFF);
      pix(1, 1, 0, 1'b0);
      chk("wrap_re", re_c[1], 32'h8000_0000);
      end_frame(s0, d0, 4);

      // single-pixel frame
      sel = 2;
      rl  = 32'h1234_5678;
      it  = 32'h9ABC_DEF0;
      stp = 32'h0000_0010;
      tick(2);
      s0 = starts;
      d0 = dones;
      go_frame();
      pix(0, 0, 0, 1'b0);
      end_frame(s0, d0, 1);
      tick(10);
      chk("one_quiet", 32'(starts - s0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end

endmodule
